// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler: round-robin arbitration of producer results onto the single
// register-file write port, plus a per-register pending-write scoreboard for decode.
module rf_wb_scheduler #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_rd,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic                 w_en,
    output logic [AW-1:0]        rd_id,
    output logic [DW-1:0]        rd_write_data,
    input  logic                 sb_set_en,
    input  logic [AW-1:0]        sb_set_rd,
    output logic                 sb_full,
    input  logic [AW-1:0]        rs1_id,
    input  logic [AW-1:0]        rs2_id,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 sb_err
);

    localparam int unsigned PW   = (NREQ > 2) ? 2 : 1;
    localparam int unsigned NREG = 1 << AW;

    logic [PW-1:0] last;
    logic          grant_valid;
    logic [PW-1:0] grant_idx;
    logic [AW-1:0] grant_rd;
    logic [DW-1:0] grant_data;

    logic [1:0]    cnt   [NREG];
    logic [1:0]    cnt_d [NREG];
    logic          set_full;
    logic          inc_en;
    logic          dec_en;
    logic          err_set;

    // Two passes give the wrap-around search order last+1 .. NREQ-1, 0 .. last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_rd    = '0;
        grant_data  = '0;
        req_ready   = '0;
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_valid && req_valid[i] && (PW'(i) > last)) begin
                    grant_valid  = 1'b1;
                    grant_idx    = PW'(i);
                    grant_rd     = req_rd[i*AW +: AW];
                    grant_data   = req_data[i*DW +: DW];
                    req_ready[i] = 1'b1;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_valid && req_valid[i] && (PW'(i) <= last)) begin
                    grant_valid  = 1'b1;
                    grant_idx    = PW'(i);
                    grant_rd     = req_rd[i*AW +: AW];
                    grant_data   = req_data[i*DW +: DW];
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last          <= PW'(NREQ - 1);
            w_en          <= 1'b0;
            rd_id         <= '0;
            rd_write_data <= '0;
        end else begin
            // Writes to x0 are consumed but never reach the register file.
            w_en <= grant_valid && (grant_rd != '0);
            if (grant_valid) begin
                last          <= grant_idx;
                rd_id         <= grant_rd;
                rd_write_data <= grant_data;
            end
        end
    end

    assign set_full = (sb_set_rd != '0) && (cnt[sb_set_rd] == 2'd3);
    assign sb_full  = set_full;
    assign inc_en   = sb_set_en && (sb_set_rd != '0) && !set_full;
    // Retire on the write actually presented to the register file this cycle.
    assign dec_en   = w_en && (rd_id != '0);
    assign err_set  = (sb_set_en && set_full) || (dec_en && (cnt[rd_id] == 2'd0));

    always_comb begin
        cnt_d[0] = 2'd0;
        for (int r = 1; r < NREG; r++) begin
            cnt_d[r] = cnt[r];
            if (inc_en && (sb_set_rd == AW'(r)) && !(dec_en && (rd_id == AW'(r)))) begin
                cnt_d[r] = cnt[r] + 2'd1;
            end else if (dec_en && (rd_id == AW'(r)) && !(inc_en && (sb_set_rd == AW'(r))) &&
                         (cnt[r] != 2'd0)) begin
                cnt_d[r] = cnt[r] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= 2'd0;
            end
            sb_err <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= cnt_d[r];
            end
            if (err_set) begin
                sb_err <= 1'b1;
            end
        end
    end

    assign rs1_busy = (rs1_id != '0) && (cnt[rs1_id] != 2'd0);
    assign rs2_busy = (rs2_id != '0) && (cnt[rs2_id] != 2'd0);

endmodule
